hoplite_arbiter: RTL and testbench

HOPLITE_ARBITER -- requirements
Module: hoplite_arbiter

---
 rtl/hoplite_arbiter.sv | 247 ++++++++++++++++++++++++
 tb/tb_hoplite_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hoplite_arbiter.sv
// Hoplite 3D-torus router arbiter: routes ring flits (Z > Y > X > PE) onto
// the X/Y/Z outputs, flags PE starvation and keeps saturating statistics.
module hoplite_arbiter #(
    parameter int unsigned FLIT_SIZE    = 128,
    parameter int unsigned COORD_W      = 2,
    parameter int unsigned STARVE_LIMIT = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [COORD_W-1:0]   cur_x,
    input  logic [COORD_W-1:0]   cur_y,
    input  logic [COORD_W-1:0]   cur_z,
    input  logic                 x_in_valid,
    input  logic                 y_in_valid,
    input  logic                 z_in_valid,
    input  logic [FLIT_SIZE-1:0] x_input,
    input  logic [FLIT_SIZE-1:0] y_input,
    input  logic [FLIT_SIZE-1:0] z_input,
    input  logic                 pe_in_valid,
    input  logic [FLIT_SIZE-1:0] pe_input,
    output logic                 pe_in_ready,
    output logic [1:0]           x_sel,
    output logic [2:0]           y_sel,
    output logic [2:0]           z_sel,
    output logic                 x_input_eject_valid,
    output logic                 y_input_eject_valid,
    output logic                 z_input_eject_valid,
    output logic                 starve_out,
    input  logic                 stat_clr,
    output logic [CNT_W-1:0]     inject_cnt,
    output logic [CNT_W-1:0]     deflect_cnt,
    output logic [CNT_W-1:0]     eject_cnt
);

    localparam int unsigned BLK_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(STARVE_LIMIT - 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, WAIT, STARVED} starve_state_e;

    logic [COORD_W-1:0] xd_x, xd_y, xd_z;
    logic [COORD_W-1:0] yd_y, yd_z;
    logic [COORD_W-1:0] zd_x, zd_y, zd_z;
    logic [COORD_W-1:0] pd_x, pd_y, pd_z;

    assign xd_x = x_input[COORD_W-1:0];
    assign xd_y = x_input[2*COORD_W-1:COORD_W];
    assign xd_z = x_input[3*COORD_W-1:2*COORD_W];
    assign yd_y = y_input[2*COORD_W-1:COORD_W];
    assign yd_z = y_input[3*COORD_W-1:2*COORD_W];
    assign zd_x = z_input[COORD_W-1:0];
    assign zd_y = z_input[2*COORD_W-1:COORD_W];
    assign zd_z = z_input[3*COORD_W-1:2*COORD_W];
    assign pd_x = pe_input[COORD_W-1:0];
    assign pd_y = pe_input[2*COORD_W-1:COORD_W];
    assign pd_z = pe_input[3*COORD_W-1:2*COORD_W];

    // Payload bits and the Y flit's X field play no part in routing.
    logic unused_payload;
    assign unused_payload = ^{x_input[FLIT_SIZE-1:3*COORD_W], y_input[FLIT_SIZE-1:3*COORD_W],
                              z_input[FLIT_SIZE-1:3*COORD_W], pe_input[FLIT_SIZE-1:3*COORD_W],
                              y_input[COORD_W-1:0]};

    logic       x_taken, y_taken, z_taken;
    logic       defl_x, defl_y;
    logic [1:0] pe_tgt;
    logic [1:0] n_defl;
    logic [1:0] n_eject;

    // Ring routing in priority order, then PE injection into what is left.
    always_comb begin
        x_sel               = 2'b00;
        y_sel               = 3'b000;
        z_sel               = 3'b000;
        x_input_eject_valid = 1'b0;
        y_input_eject_valid = 1'b0;
        z_input_eject_valid = 1'b0;
        x_taken             = 1'b0;
        y_taken             = 1'b0;
        z_taken             = 1'b0;
        defl_x              = 1'b0;
        defl_y              = 1'b0;
        pe_in_ready         = 1'b0;
        pe_tgt              = 2'd0;

        if (z_in_valid) begin
            if (zd_x == cur_x && zd_y == cur_y && zd_z == cur_z) begin
                z_input_eject_valid = 1'b1;
            end else begin
                z_sel   = 3'd3;
                z_taken = 1'b1;
            end
        end

        // A Y-ring flit has already finished its X leg.
        if (y_in_valid) begin
            if (yd_y != cur_y) begin
                y_sel   = 3'd2;
                y_taken = 1'b1;
            end else if (yd_z != cur_z) begin
                if (!z_taken) begin
                    z_sel   = 3'd2;
                    z_taken = 1'b1;
                end else begin
                    y_sel   = 3'd2;
                    y_taken = 1'b1;
                    defl_y  = 1'b1;
                end
            end else begin
                y_input_eject_valid = 1'b1;
            end
        end

        if (x_in_valid) begin
            if (xd_x != cur_x) begin
                x_sel   = 2'd1;
                x_taken = 1'b1;
            end else if (xd_y != cur_y) begin
                if (!y_taken) begin
                    y_sel   = 3'd1;
                    y_taken = 1'b1;
                end else begin
                    x_sel   = 2'd1;
                    x_taken = 1'b1;
                    defl_x  = 1'b1;
                end
            end else if (xd_z != cur_z) begin
                if (!z_taken) begin
                    z_sel   = 3'd1;
                    z_taken = 1'b1;
                end else begin
                    x_sel   = 2'd1;
                    x_taken = 1'b1;
                    defl_x  = 1'b1;
                end
            end else begin
                x_input_eject_valid = 1'b1;
            end
        end

        if (pd_x != cur_x)      pe_tgt = 2'd0;
        else if (pd_y != cur_y) pe_tgt = 2'd1;
        else if (pd_z != cur_z) pe_tgt = 2'd2;
        else                    pe_tgt = 2'd0;

        if (pe_in_valid) begin
            case (pe_tgt)
                2'd1: begin
                    if (!y_taken) begin
                        pe_in_ready = 1'b1;
                        y_sel       = 3'b100;
                    end
                end
                2'd2: begin
                    if (!z_taken) begin
                        pe_in_ready = 1'b1;
                        z_sel       = 3'b100;
                    end
                end
                default: begin
                    if (!x_taken) begin
                        pe_in_ready = 1'b1;
                        x_sel       = 2'b10;
                    end
                end
            endcase
        end
    end

    assign n_defl  = {1'b0, defl_x} + {1'b0, defl_y};
    assign n_eject = {1'b0, x_input_eject_valid} + {1'b0, y_input_eject_valid}
                   + {1'b0, z_input_eject_valid};

    starve_state_e    state;
    logic [BLK_W-1:0] blk_cnt;
    logic [BLK_W-1:0] blk_inc;
    logic             blocked;

    assign blocked = pe_in_valid & ~pe_in_ready;
    assign blk_inc = (blk_cnt == BLK_MAX) ? blk_cnt : blk_cnt + BLK_W'(1);

    // Starvation tracker; any unblocked cycle returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            blk_cnt    <= '0;
            starve_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    blk_cnt    <= '0;
                    starve_out <= 1'b0;
                    if (blocked) state <= WAIT;
                end
                WAIT: begin
                    if (!blocked) begin
                        state   <= IDLE;
                        blk_cnt <= '0;
                    end else begin
                        blk_cnt <= blk_inc;
                        if (blk_inc == BLK_MAX) begin
                            state      <= STARVED;
                            starve_out <= 1'b1;
                        end
                    end
                end
                STARVED: begin
                    if (!blocked) begin
                        state      <= IDLE;
                        blk_cnt    <= '0;
                        starve_out <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    blk_cnt    <= '0;
                    starve_out <= 1'b0;
                end
            endcase
        end
    end

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input logic [1:0] inc);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, cnt} + SUM_W'(inc);
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // Saturating statistics; clear wins over same-cycle increments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inject_cnt  <= '0;
            deflect_cnt <= '0;
            eject_cnt   <= '0;
        end else if (stat_clr) begin
            inject_cnt  <= '0;
            deflect_cnt <= '0;
            eject_cnt   <= '0;
        end else begin
            inject_cnt  <= sat_add(inject_cnt, {1'b0, pe_in_ready});
            deflect_cnt <= sat_add(deflect_cnt, n_defl);
            eject_cnt   <= sat_add(eject_cnt, n_eject);
        end
    end

endmodule

// File: tb/tb_hoplite_arbiter.sv
// Scoreboard bench for hoplite_arbiter: driver pushes model predictions,
// monitor pops and compares each cycle.
module tb_hoplite_arbiter;
    localparam int unsigned FW    = 32;
    localparam int unsigned CW    = 2;
    localparam int unsigned LIMIT = 16;
    localparam int unsigned NW    = 5;
    localparam int          MAXC  = (1 << NW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic [CW-1:0] cur_x, cur_y, cur_z;
    logic x_in_valid, y_in_valid, z_in_valid, pe_in_valid, stat_clr;
    logic [FW-1:0] x_input, y_input, z_input, pe_input;
    logic pe_in_ready, starve_out;
    logic [1:0] x_sel;
    logic [2:0] y_sel, z_sel;
    logic x_input_eject_valid, y_input_eject_valid, z_input_eject_valid;
    logic [NW-1:0] inject_cnt, deflect_cnt, eject_cnt;

    hoplite_arbiter #(.FLIT_SIZE(FW), .COORD_W(CW), .STARVE_LIMIT(LIMIT), .CNT_W(NW)) dut (
        .clk(clk), .rst_n(rst_n), .cur_x(cur_x), .cur_y(cur_y), .cur_z(cur_z),
        .x_in_valid(x_in_valid), .y_in_valid(y_in_valid), .z_in_valid(z_in_valid),
        .x_input(x_input), .y_input(y_input), .z_input(z_input),
        .pe_in_valid(pe_in_valid), .pe_input(pe_input), .pe_in_ready(pe_in_ready),
        .x_sel(x_sel), .y_sel(y_sel), .z_sel(z_sel),
        .x_input_eject_valid(x_input_eject_valid), .y_input_eject_valid(y_input_eject_valid),
        .z_input_eject_valid(z_input_eject_valid), .starve_out(starve_out),
        .stat_clr(stat_clr), .inject_cnt(inject_cnt), .deflect_cnt(deflect_cnt),
        .eject_cnt(eject_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int xs, ys, zs, ej, rdy, starve, inj, defl, ejc;
        int nd, ne;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int m_inj = 0, m_defl = 0, m_ej = 0, m_run = 0, m_starve = 0;

    function automatic logic [FW-1:0] mk(input int x, input int y, input int z);
        logic [FW-1:0] f;
        f = FW'($urandom);
        f[1:0] = 2'(x);
        f[3:2] = 2'(y);
        f[5:4] = 2'(z);
        return f;
    endfunction

    function automatic int fld(input logic [FW-1:0] f, input int k);
        return int'(f[2*k +: 2]);
    endfunction

    // Reference: each ring flit wants the first unfinished dimension at or
    // after its own ring; if that output is taken it stays on its own ring.
    function automatic exp_t model();
        exp_t e;
        int sel[3];
        bit taken[3];
        int c[3];
        int want, pw;
        logic v;
        logic [FW-1:0] f;
        c[0] = int'(cur_x); c[1] = int'(cur_y); c[2] = int'(cur_z);
        for (int k = 0; k < 3; k++) begin sel[k] = 0; taken[k] = 0; end
        e.ej = 0; e.nd = 0; e.ne = 0;
        for (int s = 2; s >= 0; s--) begin
            v = (s == 2) ? z_in_valid : (s == 1) ? y_in_valid : x_in_valid;
            f = (s == 2) ? z_input : (s == 1) ? y_input : x_input;
            if (v) begin
                want = -1;
                if (s == 2) begin
                    for (int k = 0; k < 3; k++) if (fld(f, k) != c[k]) want = 2;
                end else begin
                    for (int k = s; k < 3; k++) if (want < 0 && fld(f, k) != c[k]) want = k;
                end
                if (want < 0) begin
                    e.ej = e.ej | (1 << s);
                    e.ne++;
                end else if (want == s || !taken[want]) begin
                    taken[want] = 1; sel[want] = s + 1;
                end else begin
                    taken[s] = 1; sel[s] = s + 1; e.nd++;
                end
            end
        end
        pw = -1;
        for (int k = 0; k < 3; k++) if (pw < 0 && fld(pe_input, k) != c[k]) pw = k;
        if (pw < 0) pw = 0;
        e.rdy = (pe_in_valid && !taken[pw]) ? 1 : 0;
        if (e.rdy == 1) sel[pw] = 4;
        e.xs = (sel[0] == 4) ? 2 : sel[0];
        e.ys = sel[1];
        e.zs = sel[2];
        return e;
    endfunction

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    // One cycle: predict, push, then advance the model across the clock edge.
    task automatic cycle(input string tag);
        exp_t e;
        if (!rst_n) begin
            m_inj = 0; m_defl = 0; m_ej = 0; m_run = 0; m_starve = 0;
        end
        #1;
        e = model();
        e.tag = tag;
        e.starve = m_starve; e.inj = m_inj; e.defl = m_defl; e.ejc = m_ej;
        exp_q.push_back(e);
        @(posedge clk);
        if (rst_n) begin
            if (pe_in_valid && e.rdy == 0) m_run = (m_run < 1000) ? m_run + 1 : m_run;
            else m_run = 0;
            m_starve = (m_run >= int'(LIMIT)) ? 1 : 0;
            if (stat_clr) begin
                m_inj = 0; m_defl = 0; m_ej = 0;
            end else begin
                m_inj = sat(m_inj + e.rdy);
                m_defl = sat(m_defl + e.nd);
                m_ej = sat(m_ej + e.ne);
            end
        end
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input string nm, input int act, input int ex);
        checks++;
        if (act != ex) begin
            failures++;
            $display("FAIL %s.%s actual=%0d expected=%0d @%0t", tag, nm, act, ex, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.tag, "x_sel", int'(x_sel), e.xs);
                chk(e.tag, "y_sel", int'(y_sel), e.ys);
                chk(e.tag, "z_sel", int'(z_sel), e.zs);
                chk(e.tag, "eject", int'({z_input_eject_valid, y_input_eject_valid, x_input_eject_valid}), e.ej);
                chk(e.tag, "pe_in_ready", int'(pe_in_ready), e.rdy);
                chk(e.tag, "starve_out", int'(starve_out), e.starve);
                chk(e.tag, "inject_cnt", int'(inject_cnt), e.inj);
                chk(e.tag, "deflect_cnt", int'(deflect_cnt), e.defl);
                chk(e.tag, "eject_cnt", int'(eject_cnt), e.ejc);
            end
        end
    end

    task automatic idle_inputs();
        x_in_valid = 0; y_in_valid = 0; z_in_valid = 0; pe_in_valid = 0; stat_clr = 0;
        x_input = '0; y_input = '0; z_input = '0; pe_input = '0;
    endtask

    task automatic set_cur(input int x, input int y, input int z);
        cur_x = 2'(x); cur_y = 2'(y); cur_z = 2'(z);
    endtask

    task automatic starve_run(input int n, input string tag);
        set_cur(0, 0, 0);
        idle_inputs();
        pe_in_valid = 1; pe_input = mk(3, 0, 0);
        x_in_valid = 1; x_input = mk(2, 0, 0);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    initial begin : driver
        int cx, cy, cz;
        rst_n = 0;
        idle_inputs();
        set_cur(0, 0, 0);
        @(negedge clk);
        cycle("reset");
        rst_n = 1;
        cycle("post_reset");

        set_cur(1, 1, 1);
        x_in_valid = 1; x_input = mk(2, 1, 1);
        cycle("x_pass");
        idle_inputs();
        cycle("x_pass_after");

        z_in_valid = 1; z_input = mk(1, 1, 2);
        y_in_valid = 1; y_input = mk(1, 1, 3);
        x_in_valid = 1; x_input = mk(1, 2, 1);
        cycle("double_deflect");
        idle_inputs();
        cycle("double_deflect_after");

        set_cur(0, 0, 0);
        z_in_valid = 1; z_input = mk(0, 0, 0);
        y_in_valid = 1; y_input = mk(0, 0, 0);
        x_in_valid = 1; x_input = mk(0, 0, 0);
        cycle("triple_eject");
        idle_inputs();
        cycle("triple_eject_after");

        starve_run(18, "starve");
        x_in_valid = 0;
        cycle("starve_release");
        pe_in_valid = 0;
        cycle("starve_exit");
        cycle("starve_exit2");

        pe_in_valid = 1; pe_input = mk(0, 2, 0); stat_clr = 1;
        cycle("clr_vs_inject");
        idle_inputs();
        cycle("clr_vs_inject_after");

        starve_run(18, "starve2");
        rst_n = 0;
        cycle("reset_in_starve");
        rst_n = 1;
        idle_inputs();
        cycle("reset_in_starve_after");

        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) begin
                cx = int'($urandom_range(0, 3)); cy = int'($urandom_range(0, 3)); cz = int'($urandom_range(0, 3));
                set_cur(cx, cy, cz);
            end
            z_in_valid = ($urandom_range(0, 1) == 1);
            y_in_valid = ($urandom_range(0, 1) == 1);
            x_in_valid = ($urandom_range(0, 3) != 0);
            pe_in_valid = ($urandom_range(0, 3) != 0);
            z_input = mk(($urandom_range(0, 1) == 1) ? cx : int'($urandom_range(0, 3)),
                         ($urandom_range(0, 1) == 1) ? cy : int'($urandom_range(0, 3)),
                         ($urandom_range(0, 1) == 1) ? cz : int'($urandom_range(0, 3)));
            y_input = mk(cx,
                         ($urandom_range(0, 1) == 1) ? cy : int'($urandom_range(0, 3)),
                         ($urandom_range(0, 1) == 1) ? cz : int'($urandom_range(0, 3)));
            x_input = mk(($urandom_range(0, 1) == 1) ? cx : int'($urandom_range(0, 3)),
                         ($urandom_range(0, 1) == 1) ? cy : int'($urandom_range(0, 3)),
                         ($urandom_range(0, 1) == 1) ? cz : int'($urandom_range(0, 3)));
            pe_input = mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            stat_clr = ($urandom_range(0, 99) == 0);
            cycle("random");
        end
        idle_inputs();
        cycle("final");
        #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
